// File: rtl/pos_dac_pkg.sv
// Shared definitions for the positioning-loop DAC serial transmitter.
// Holds the frame width, the parameter defaults, the FSM state encoding
// and a small helper for loading the down-counting phase timer.
package pos_dac_pkg;

  localparam int FRAME_W        = 16;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_CS_SETUP   = 1;
  localparam int DEF_LDAC_WIDTH = 2;
  localparam int TMR_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_CSHOLD = 3'd3,
    ST_LDAC   = 3'd4,
    ST_DONE   = 3'd5
  } dac_state_e;

  // A phase lasting n cycles loads n-1 and ends when the timer reads zero.
  function automatic logic [TMR_W-1:0] tmr_load(input int n);
    return TMR_W'(n - 1);
  endfunction

endpackage

// File: rtl/pos_dac_sclk_div.sv
// SCLK half-period tick generator.
// Ports:
//   clk_pid  - clock
//   sys_rst  - asynchronous active-high reset
//   en       - count while high; counter held at zero while low
//   tick     - high in the last cycle of each CLK_DIV-cycle half-period
module pos_dac_sclk_div
  import pos_dac_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_pid,
  input  logic sys_rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  assign last = (cnt_q == CW'(CLK_DIV - 1));
  assign tick = en && last;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_pid or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pos_dac_tx.sv
// Serial writer for the positioning-loop DAC: shifts a 16-bit offset-binary
// code out MSB first under csn, then pulses ldacn to update the output.
// A start arriving while a frame is running is parked in a one-deep
// pending slot (newest wins) and sent straight after the current frame.
// Ports:
//   clk_pid, sys_rst       - clock, asynchronous active-high reset
//   dac_data, dac_start    - code to write and single-cycle write request
//   dac_sclk/csn/sdi/ldacn - DAC serial interface
//   busy, done             - frame in progress, end-of-frame pulse
//
// state  | meaning
// IDLE   | waiting for dac_start
// SETUP  | csn low, MSB on sdi, sclk low, CS_SETUP cycles
// SHIFT  | 16 sclk periods, high half first; sdi shifts on falling edges
// CSHOLD | one cycle with csn high before the load strobe
// LDAC   | ldacn low for LDAC_WIDTH cycles
// DONE   | one-cycle done pulse; chains to SETUP if a write is waiting
module pos_dac_tx
  import pos_dac_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int CS_SETUP   = DEF_CS_SETUP,
  parameter int LDAC_WIDTH = DEF_LDAC_WIDTH
) (
  input  logic               clk_pid,
  input  logic               sys_rst,
  input  logic [FRAME_W-1:0] dac_data,
  input  logic               dac_start,
  output logic               dac_sclk,
  output logic               dac_csn,
  output logic               dac_sdi,
  output logic               dac_ldacn,
  output logic               busy,
  output logic               done
);

  localparam int BIT_W = $clog2(FRAME_W);

  dac_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] pend_data_q, pend_data_d;
  logic               pend_valid_q, pend_valid_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               sclk_q, sclk_d;
  logic               shift_en;
  logic               half_tick;

  assign shift_en = (state_q == ST_SHIFT);

  pos_dac_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_div (
    .clk_pid (clk_pid),
    .sys_rst (sys_rst),
    .en      (shift_en),
    .tick    (half_tick)
  );

  assign dac_sclk  = sclk_q;
  assign dac_sdi   = shift_q[FRAME_W-1];
  assign dac_csn   = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
  assign dac_ldacn = (state_q != ST_LDAC);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    bit_d        = bit_q;
    tmr_d        = tmr_q;
    sclk_d       = sclk_q;

    // Starts during a frame park in the pending slot; DONE may override below.
    if (dac_start && (state_q != ST_IDLE)) begin
      pend_valid_d = 1'b1;
      pend_data_d  = dac_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (dac_start) begin
          shift_d = dac_data;
          tmr_d   = tmr_load(CS_SETUP);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sclk_d = 1'b0;
        if (tmr_q == '0) begin
          sclk_d  = 1'b1;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SHIFT: begin
        if (half_tick) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end else if (bit_q == BIT_W'(FRAME_W - 1)) begin
            state_d = ST_CSHOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_W'(1);
          end
        end
      end
      ST_CSHOLD: begin
        tmr_d   = tmr_load(LDAC_WIDTH);
        state_d = ST_LDAC;
      end
      ST_LDAC: begin
        if (tmr_q == '0) begin
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DONE: begin
        // A start in this very cycle is newer than anything pending.
        if (dac_start || pend_valid_q) begin
          shift_d      = dac_start ? dac_data : pend_data_q;
          pend_valid_d = 1'b0;
          tmr_d        = tmr_load(CS_SETUP);
          state_d      = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pid or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      bit_q        <= '0;
      tmr_q        <= '0;
      sclk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      bit_q        <= bit_d;
      tmr_q        <= tmr_d;
      sclk_q       <= sclk_d;
    end
  end

endmodule

// File: tb/tb_pos_dac_tx.sv
// Bench for pos_dac_tx: instance 0 uses defaults, instance 1 uses CLK_DIV=3.
// A frame-position reference model predicts every output each cycle; a frame
// monitor reassembles the word seen on sdi at sclk rises.
module tb_pos_dac_tx;

  localparam int CSS = 1;
  localparam int LW  = 2;

  logic        clk_pid = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  st = '0;
  logic [15:0] dat [2];
  logic [1:0]  sclk, csn, sdi, ldacn, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_pid = ~clk_pid;

  pos_dac_tx u_dut0 (
    .clk_pid (clk_pid), .sys_rst (sys_rst), .dac_data (dat[0]), .dac_start (st[0]),
    .dac_sclk (sclk[0]), .dac_csn (csn[0]), .dac_sdi (sdi[0]), .dac_ldacn (ldacn[0]),
    .busy (busy[0]), .done (done[0])
  );

  pos_dac_tx #(.CLK_DIV(3)) u_dut1 (
    .clk_pid (clk_pid), .sys_rst (sys_rst), .dac_data (dat[1]), .dac_start (st[1]),
    .dac_sclk (sclk[1]), .dac_csn (csn[1]), .dac_sdi (sdi[1]), .dac_ldacn (ldacn[1]),
    .busy (busy[1]), .done (done[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  // A frame is numbered by cycle position fc = 1..N after the accepting edge.
  bit          m_busy [2];
  int          m_fc   [2];
  logic [15:0] m_cur  [2];
  logic [15:0] m_pd   [2];
  bit          m_pv   [2];

  function automatic int clk_div_of(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int frame_len(int i);
    return 1 + CSS + 32 * clk_div_of(i) + 1 + LW;
  endfunction

  function automatic void model_step(int i, logic s, logic [15:0] d);
    if (m_busy[i]) begin
      if (m_fc[i] == frame_len(i)) begin
        if (s || m_pv[i]) begin
          m_cur[i] = s ? d : m_pd[i];
          m_pv[i]  = 1'b0;
          m_fc[i]  = 1;
        end else begin
          m_busy[i] = 1'b0;
          m_fc[i]   = 0;
        end
      end else begin
        if (s) begin
          m_pv[i] = 1'b1;
          m_pd[i] = d;
        end
        m_fc[i]++;
      end
    end else if (s) begin
      m_busy[i] = 1'b1;
      m_fc[i]   = 1;
      m_cur[i]  = d;
    end
  endfunction

  // Expected {sclk, csn, sdi, ldacn, busy, done}; sv says whether sdi is defined.
  function automatic void exp_out(int i, output logic [5:0] e, output bit sv);
    int cd, se, fc, p, h, k;
    logic [15:0] w;
    logic sc, cl, sd, ll, dn;
    cd = clk_div_of(i);
    se = CSS + 32 * cd;
    fc = m_fc[i];
    w  = m_cur[i];
    sc = 1'b0; sd = 1'b0; sv = 1'b0;
    cl = m_busy[i] && (fc >= 1) && (fc <= se);
    ll = m_busy[i] && (fc > se + 1) && (fc <= se + 1 + LW);
    dn = m_busy[i] && (fc == frame_len(i));
    if (cl) begin
      p = fc - CSS - 1;
      k = 0;
      if (p >= 0) begin
        h  = p / cd;
        sc = ((h % 2) == 0);
        k  = (h + 1) / 2;
      end
      if (k < 16) begin
        sv = 1'b1;
        sd = w[15 - k];
      end
    end
    e = {sc, !cl, sd, !ll, m_busy[i], dn};
  endfunction

  always @(posedge clk_pid or posedge sys_rst) begin
    for (int i = 0; i < 2; i++) begin
      if (sys_rst) begin
        m_busy[i] = 1'b0; m_fc[i] = 0; m_pv[i] = 1'b0;
        m_cur[i] = '0; m_pd[i] = '0;
      end else begin
        model_step(i, st[i], dat[i]);
      end
    end
  end

  // ---------------- per-cycle compare and frame monitor ----------------
  logic [15:0] acc [2];
  logic [15:0] last_word [2];
  logic        prev_sclk [2];
  int          rise_cnt [2], csn_cnt [2], ldac_cnt [2];
  int          last_csn [2], last_ldac [2], done_cnt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc[i] = '0; last_word[i] = '0; prev_sclk[i] = 1'b0;
      rise_cnt[i] = 0; csn_cnt[i] = 0; ldac_cnt[i] = 0;
      last_csn[i] = 0; last_ldac[i] = 0; done_cnt[i] = 0;
    end
  end

  always @(negedge clk_pid) begin
    for (int i = 0; i < 2; i++) begin
      logic [5:0] e, a, msk;
      bit sv;
      exp_out(i, e, sv);
      a   = {sclk[i], csn[i], sdi[i], ldacn[i], busy[i], done[i]};
      msk = sv ? 6'b111111 : 6'b110111;
      chk((i == 0) ? "cycle_outputs_div2" : "cycle_outputs_div3",
          {26'b0, a & msk}, {26'b0, e & msk});
      if (sys_rst) begin
        acc[i] = '0; rise_cnt[i] = 0; csn_cnt[i] = 0; ldac_cnt[i] = 0;
        prev_sclk[i] = 1'b0;
      end else begin
        if (sclk[i] && !prev_sclk[i]) begin
          acc[i] = {acc[i][14:0], sdi[i]};
          rise_cnt[i]++;
        end
        prev_sclk[i] = sclk[i];
        if (!csn[i])   csn_cnt[i]++;
        if (!ldacn[i]) ldac_cnt[i]++;
        if (done[i]) begin
          chk("frame_word_and_rises", {rise_cnt[i][15:0], acc[i]}, {16'd16, m_cur[i]});
          last_word[i] = acc[i];
          last_csn[i]  = csn_cnt[i];
          last_ldac[i] = ldac_cnt[i];
          done_cnt[i]++;
          acc[i] = '0; rise_cnt[i] = 0; csn_cnt[i] = 0; ldac_cnt[i] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_pid);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget, output int cyc, output int blo);
    bit ok;
    ok = 1'b0; cyc = 0; blo = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      if (!busy[i]) blo++;
      if (done[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_within_budget", {31'b0, ok}, 32'd1);
  endtask

  // Start a frame (data scrambled after capture) and return done latency.
  task automatic run_frame(input int i, input logic [15:0] d, output int lat);
    int c, b;
    st[i] = 1'b1; dat[i] = d;
    tick();
    st[i] = 1'b0; dat[i] = 16'($urandom);
    wait_done(i, 300, c, b);
    lat = c + 1;
  endtask

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          lat;
    int          csn_n;
    int          ldac_n;
  } vec_t;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [6];
    int lat, c, b1, b2, d0, lo;

    vt[0] = '{0, 16'h8000,  69, 65, 2};
    vt[1] = '{1, 16'hA5C3, 101, 97, 2};
    vt[2] = '{0, 16'hFFFF,  69, 65, 2};
    vt[3] = '{0, 16'h0000,  69, 65, 2};
    vt[4] = '{1, 16'h5A3C, 101, 97, 2};
    vt[5] = '{0, 16'h7FFF,  69, 65, 2};

    dat[0] = '0; dat[1] = '0;

    // Reset values while held in reset.
    #2;
    chk("reset_outputs_div2", {26'b0, sclk[0], csn[0], sdi[0], ldacn[0], busy[0], done[0]}, 32'b010100);
    chk("reset_outputs_div3", {26'b0, sclk[1], csn[1], sdi[1], ldacn[1], busy[1], done[1]}, 32'b010100);
    repeat (3) tick();
    sys_rst = 1'b0;
    repeat (3) tick();

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      run_frame(vt[v].inst, vt[v].data, lat);
      chk("latency", lat, vt[v].lat);
      chk("word", {16'b0, last_word[vt[v].inst]}, {16'b0, vt[v].data});
      chk("csn_low_cycles", last_csn[vt[v].inst], vt[v].csn_n);
      chk("ldacn_low_cycles", last_ldac[vt[v].inst], vt[v].ldac_n);
      repeat (5) tick();
    end

    // Two starts during a frame: only the newest survives, busy never drops.
    d0 = done_cnt[0];
    st[0] = 1'b1; dat[0] = 16'h1234; tick();
    st[0] = 1'b0; repeat (10) tick();
    st[0] = 1'b1; dat[0] = 16'h5678; tick();
    st[0] = 1'b0; repeat (10) tick();
    st[0] = 1'b1; dat[0] = 16'h9ABC; tick();
    st[0] = 1'b0; dat[0] = 16'h0F0F;
    wait_done(0, 200, c, b1);
    chk("pend_first_word", {16'b0, last_word[0]}, 32'h1234);
    wait_done(0, 200, c, b2);
    chk("pend_second_word", {16'b0, last_word[0]}, 32'h9ABC);
    chk("pend_busy_gap", b1 + b2, 0);
    repeat (150) tick();
    chk("pend_done_pulses", done_cnt[0] - d0, 2);

    // Start in the DONE cycle chains straight into SETUP.
    st[0] = 1'b1; dat[0] = 16'h4321; tick();
    st[0] = 1'b0;
    wait_done(0, 200, c, b1);
    st[0] = 1'b1; dat[0] = 16'h0001; tick();
    st[0] = 1'b0; dat[0] = 16'hFFFF;
    chk("chain_csn_low", {31'b0, csn[0]}, 32'd0);
    chk("chain_busy", {31'b0, busy[0]}, 32'd1);
    chk("chain_prev_word", {16'b0, last_word[0]}, 32'h4321);
    wait_done(0, 200, c, b1);
    chk("chain_word", {16'b0, last_word[0]}, 32'h0001);
    chk("chain_latency", c + 1, 69);
    repeat (5) tick();

    // Reset at the 8th sclk rise aborts the frame with no load strobe.
    st[0] = 1'b1; dat[0] = 16'hABCD; tick();
    st[0] = 1'b0;
    c = 0;
    while (rise_cnt[0] != 8 && c < 200) begin
      tick();
      c++;
    end
    chk("rise8_reached", rise_cnt[0], 8);
    sys_rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", {26'b0, sclk[0], csn[0], sdi[0], ldacn[0], busy[0], done[0]}, 32'b010100);
    lo = 0;
    repeat (3) begin
      tick();
      if (!ldacn[0]) lo++;
    end
    sys_rst = 1'b0;
    repeat (80) begin
      tick();
      if (!ldacn[0]) lo++;
    end
    chk("no_ldac_after_abort", lo, 0);
    run_frame(0, 16'hFFFF, lat);
    chk("post_reset_latency", lat, 69);
    chk("post_reset_word", {16'b0, last_word[0]}, 32'hFFFF);

    // Random starts on both instances, checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        st[i]  = ($urandom_range(0, 29) == 0);
        dat[i] = 16'($urandom);
      end
    end
    st = '0;
    repeat (250) tick();
    chk("random_drained_idle", {30'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pos_dac_tx.md
POS_DAC_TX -- requirements
Module: pos_dac_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, 2, clk_pid cycles per SCLK half-period (>=1).
REQ-002 SHALL have parameter CS_SETUP, 1, clk_pid cycles from csn low to first SCLK rise (>=1).
REQ-003 SHALL have parameter LDAC_WIDTH, 2, clk_pid cycles of dac_ldacn low (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports clk_pid and sys_rst.
REQ-005 Port: clk_pid  input  1  sole clock, rising edge.
REQ-006 Port: sys_rst  input  1  asynchronous reset, active high.
REQ-007 Port: dac_data  input  16  offset-binary DAC code (32768 = midscale), from PID output.
REQ-008 Port: dac_start  input  1  single-cycle request to write dac_data.
REQ-009 Port: dac_sclk  output  1  serial clock, idle low.
REQ-010 Port: dac_csn  output  1  chip select, active low.
REQ-011 Port: dac_sdi  output  1  serial data, MSB first.
REQ-012 Port: dac_ldacn  output  1  load-DAC strobe, active low.
REQ-013 Port: busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-014 Port: done  output  1  one-cycle pulse at end of each frame.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, SHIFT, CSHOLD, LDAC, DONE.
REQ-016 IDLE: dac_start high -> capture dac_data into 16-bit shift register, go SETUP.
REQ-017 SETUP: csn=0, sdi=shift[15], sclk=0 for CS_SETUP cycles, then SHIFT.
REQ-018 SHIFT: sclk toggles every CLK_DIV cycles, 16 rise/fall pairs (32*CLK_DIV cycles total); sdi updates only on sclk falling edge, stable across every rising edge.
REQ-019 SHIFT exit: after 16th falling edge sclk=0, go CSHOLD; CSHOLD lasts 1 cycle with csn=1.
REQ-020 LDAC: ldacn=0 for LDAC_WIDTH cycles, csn=1, then DONE.
REQ-021 DONE: done=1 for exactly one cycle; next state SETUP if pending set, else IDLE.
REQ-022 Latency: done asserted 1+CS_SETUP+32*CLK_DIV+1+LDAC_WIDTH cycles after accepting start edge (69 with defaults).
REQ-023 dac_start while not IDLE: SHALL store dac_data in a one-deep pending register and set pending; later starts overwrite it (newest wins), no frame dropped other than overwritten values.
REQ-024 Leaving DONE with pending: load pending data into shift register, clear pending same cycle; a dac_start in that same DONE cycle SHALL overwrite pending before load.
REQ-025 dac_start in IDLE with pending clear SHALL never set pending.
REQ-026 Frame in progress SHALL NOT be altered by dac_data changes after capture.
REQ-027 csn SHALL stay low continuously from SETUP entry to SHIFT exit; ldacn never low while csn low.

Reset
REQ-028 sys_rst high SHALL immediately force: state IDLE, dac_sclk=0, dac_csn=1, dac_sdi=0, dac_ldacn=1, busy=0, done=0, pending=0, counters 0.
REQ-029 Reset mid-frame SHALL abort without ldacn pulse; first start after release begins a full new frame.

Structure
REQ-030 Package pos_dac_pkg SHALL hold the state enumeration, frame width constant (16) and parameter defaults.
REQ-031 SCLK half-period tick generator SHALL be sub-module pos_dac_sclk_div (enable in, tick out, CLK_DIV parameter); rest flat.

Verification
REQ-032 Start with 16'h8000, defaults -> sdi bits 1000_0000_0000_0000 sampled on 16 sclk rises, csn low 65 cycles, ldacn low 2 cycles, done 69 cycles after start.
REQ-033 Start with 16'hA5C3, CLK_DIV=3 -> captured word 16'hA5C3, sclk period 6 cycles, sdi unchanged at every rise, done after 1+1+96+1+2=101 cycles.
REQ-034 Start 16'h1234, then starts 16'h5678 and 16'h9ABC during frame -> frames 16'h1234 then 16'h9ABC only, two done pulses, busy continuous.
REQ-035 Assert sys_rst at 8th sclk rise -> outputs at reset values same cycle, no ldacn pulse; start 16'hFFFF after release -> clean full frame.
REQ-036 Start 16'h0001 in DONE cycle of prior frame -> next SETUP entered immediately, frame 16'h0001 transmitted, no idle gap.
